// File: rtl/sne_pkg.sv
// Shared types and defaults for the event-driven neuron state memory.
package sne_pkg;

    localparam int SEQ_ADDR_WIDTH  = 4;
    localparam int EVT_WAKE_CYCLES = 4;

    typedef enum logic [1:0] {
        EVT_ACTIVE,
        EVT_CLEAR,
        EVT_SLEEP,
        EVT_WAKE
    } evt_mem_state_e;

endpackage

// File: rtl/evt_state_bank.sv
// One neuron-state bank: 1R1W, byte-enable write, write-first forwarding,
// registered read data returned one cycle after the request.
module evt_state_bank #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        rd_word   = mem[rd_addr];
        wr_merged = mem[wr_addr];
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
        // a colliding write wins over the stored word
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_word = wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: rtl/evt_state_memory_banked.sv
// Banked neuron-state memory with bulk clear and retention sleep/wake control.
module evt_state_memory_banked
    import sne_pkg::*;
#(
    parameter int NUM_GROUPS  = 16,
    parameter int ADDR_WIDTH  = SEQ_ADDR_WIDTH,
    parameter int DATA_WIDTH  = 32,
    parameter int WAKE_CYCLES = EVT_WAKE_CYCLES
) (
    input  logic                                engine_clk_i,
    input  logic                                engine_rst_ni,
    input  logic [NUM_GROUPS-1:0]               group_clk_en_i,
    input  logic                                clear_req_i,
    input  logic                                sleep_req_i,
    output logic                                sleep_ack_o,
    output logic                                busy_o,
    input  logic [NUM_GROUPS-1:0]               rd_req_i,
    input  logic [NUM_GROUPS*ADDR_WIDTH-1:0]    rd_addr_i,
    output logic [NUM_GROUPS-1:0]               rd_gnt_o,
    output logic [NUM_GROUPS-1:0]               rd_valid_o,
    output logic [NUM_GROUPS*DATA_WIDTH-1:0]    rd_data_o,
    input  logic [NUM_GROUPS-1:0]               wr_req_i,
    input  logic [NUM_GROUPS*ADDR_WIDTH-1:0]    wr_addr_i,
    input  logic [NUM_GROUPS*DATA_WIDTH-1:0]    wr_data_i,
    input  logic [NUM_GROUPS*DATA_WIDTH/8-1:0]  wr_be_i,
    output logic [NUM_GROUPS-1:0]               wr_gnt_o
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int WCW = $clog2(WAKE_CYCLES + 1);

    evt_mem_state_e        state, state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [WCW-1:0]        wake_cnt;
    logic                  ack_q, ack_d;
    logic                  active, clearing;

    always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
        if (!engine_rst_ni) begin
            state    <= EVT_ACTIVE;
            clr_cnt  <= '0;
            wake_cnt <= '0;
            ack_q    <= 1'b0;
        end else begin
            state    <= state_next;
            ack_q    <= ack_d;
            clr_cnt  <= (state == EVT_CLEAR) ? clr_cnt + ADDR_WIDTH'(1) : '0;
            wake_cnt <= (state == EVT_WAKE) ? wake_cnt + WCW'(1) : '0;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EVT_ACTIVE: begin
                if (clear_req_i) begin
                    state_next = EVT_CLEAR;
                end else if (sleep_req_i) begin
                    state_next = EVT_SLEEP;
                end
            end
            EVT_CLEAR: begin
                if (clr_cnt == '1) state_next = EVT_ACTIVE;
            end
            EVT_SLEEP: begin
                if (!sleep_req_i) state_next = EVT_WAKE;
            end
            EVT_WAKE: begin
                if (wake_cnt == WCW'(WAKE_CYCLES - 1)) state_next = EVT_ACTIVE;
            end
            default: state_next = EVT_ACTIVE;
        endcase
    end

    always_comb begin
        active   = (state == EVT_ACTIVE);
        clearing = (state == EVT_CLEAR);
        busy_o   = clearing || (state == EVT_WAKE);
        // ack rises one cycle after entering sleep and stays while sleeping
        ack_d    = (state == EVT_SLEEP) && (state_next == EVT_SLEEP);
    end

    assign sleep_ack_o = ack_q;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_bank
        logic                  wr_en;
        logic [ADDR_WIDTH-1:0] wr_addr;
        logic [DATA_WIDTH-1:0] wr_data;
        logic [NB-1:0]         wr_be;

        assign rd_gnt_o[g] = active && rd_req_i[g] && group_clk_en_i[g];
        assign wr_gnt_o[g] = active && wr_req_i[g] && group_clk_en_i[g];

        // clearing overrides the write port regardless of bank enable
        assign wr_en   = clearing || wr_gnt_o[g];
        assign wr_addr = clearing ? clr_cnt : wr_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_data = clearing ? '0 : wr_data_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign wr_be   = clearing ? '1 : wr_be_i[g*NB +: NB];

        evt_state_bank #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk      (engine_clk_i),
            .rst_n    (engine_rst_ni),
            .rd_en    (rd_gnt_o[g]),
            .rd_addr  (rd_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .wr_be    (wr_be),
            .rd_valid (rd_valid_o[g]),
            .rd_data  (rd_data_o[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
